reg_share_arbiter: RTL and testbench

//  Shares one WIDTH-bit storage register, built from D flip-flop cells, between two writers, A and B.

---
 rtl/reg_share_arbiter_pkg.sv | 26 ++
 rtl/reg_share_arbiter_dff_reg.sv | 28 ++
 rtl/reg_share_arbiter.sv | 127 ++++++++++++
 tb/tb_reg_share_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the two-writer register arbiter: state encodings,
// priority type and small decode helpers used by the top level.
package reg_share_arbiter_pkg;

  // 2-bit state encodings; encoding 3 is illegal and recovers to IDLE
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  // Which side wins a simultaneous request from IDLE
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  // True when the state is one of the two legal ownership states
  function automatic logic is_owned(input logic [1:0] st);
    return (st == ST_OWN_A) || (st == ST_OWN_B);
  endfunction

  // Priority handed to the opposite side once an owner gives up the register
  function automatic prio_t prio_after_leaving(input logic [1:0] st);
    return (st == ST_OWN_A) ? PRIO_B : PRIO_A;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_dff_reg.sv
// WIDTH-bit storage register built from individual D flip-flop cells, each
// with an asynchronous active-high clear and a shared load enable.
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    // One D flip-flop per bit: clear on reset, load D when enabled
    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        r_q[g] <= 1'b0;
      end else if (En) begin
        r_q[g] <= D[g];
      end
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one register between writers A and B.
// Grants are registered; an owner that keeps writing while the other side
// waits is forced to hand over after MAX_HOLD writes, with no idle cycle.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic [WIDTH-1:0] DataA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] DataB,
  output logic             GntA,
  output logic             GntB,
  output logic [WIDTH-1:0] Q,
  output logic             Busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  // Count value before the write that completes an ownership block
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  // Saturation value of the write counter
  localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    r_hold_cnt;
  logic [CW-1:0]    w_hold_nxt;
  prio_t            r_prio;
  prio_t            w_prio_nxt;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             w_we;
  logic             w_state_change;
  logic [WIDTH-1:0] w_wdata;

  // The only write path: an owner that is still requesting
  assign w_we    = (r_gnt_a & ReqA) | (r_gnt_b & ReqB);
  // Grants are one-hot, so selecting on A's grant is sufficient
  assign w_wdata = r_gnt_a ? DataA : DataB;

  // Next-state decision: tie-break by prio, release on drop, forced rotation
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ReqA && ReqB) begin
          w_state_nxt = (r_prio == PRIO_A) ? ST_OWN_A : ST_OWN_B;
        end else if (ReqA) begin
          w_state_nxt = ST_OWN_A;
        end else if (ReqB) begin
          w_state_nxt = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (!ReqA) begin
          w_state_nxt = ReqB ? ST_OWN_B : ST_IDLE;
        end else if (ReqB && (r_hold_cnt == HOLD_LAST)) begin
          w_state_nxt = ST_OWN_B;
        end
      end
      ST_OWN_B: begin
        if (!ReqB) begin
          w_state_nxt = ReqA ? ST_OWN_A : ST_IDLE;
        end else if (ReqA && (r_hold_cnt == HOLD_LAST)) begin
          w_state_nxt = ST_OWN_A;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_state_change = (w_state_nxt != r_state);

  // Write counter: cleared on any state change, otherwise counts writes up to saturation
  always_comb begin
    w_hold_nxt = r_hold_cnt;
    if (w_state_change) begin
      w_hold_nxt = '0;
    end else if (w_we && (r_hold_cnt != HOLD_SAT)) begin
      w_hold_nxt = r_hold_cnt + CW'(1);
    end
  end

  // Priority flips to the other side whenever an ownership state is left
  always_comb begin
    w_prio_nxt = r_prio;
    if (is_owned(r_state) && w_state_change) begin
      w_prio_nxt = prio_after_leaving(r_state);
    end
  end

  // Arbiter state, counter, priority and registered grants
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_prio     <= PRIO_A;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_prio     <= w_prio_nxt;
      r_gnt_a    <= (w_state_nxt == ST_OWN_A);
      r_gnt_b    <= (w_state_nxt == ST_OWN_B);
    end
  end

  dff_reg #(
    .WIDTH (WIDTH)
  ) u_store (
    .Clock (Clock),
    .Reset (Reset),
    .En    (w_we),
    .D     (w_wdata),
    .Q     (Q)
  );

  assign GntA = r_gnt_a;
  assign GntB = r_gnt_b;
  assign Busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: scenario tasks with a queue of
// expected register contents pushed as writes are driven.
module tb_reg_share_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             ReqA  = 1'b0;
  logic             ReqB  = 1'b0;
  logic [WIDTH-1:0] DataA = '0;
  logic [WIDTH-1:0] DataB = '0;
  logic             GntA;
  logic             GntB;
  logic [WIDTH-1:0] Q;
  logic             Busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];

  reg_share_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .ReqA  (ReqA),
    .DataA (DataA),
    .ReqB  (ReqB),
    .DataB (DataB),
    .GntA  (GntA),
    .GntB  (GntB),
    .Q     (Q),
    .Busy  (Busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #50000;
    $display("FAIL watchdog: time %0t, limit 50000", $time);
    $fatal(1, "simulation timeout");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    ReqA  = 1'b0;
    ReqB  = 1'b0;
    exp_q.delete();
    tick();
    Reset = 1'b0;
  endtask

  // Owner expected after edge k while both sides request continuously
  function automatic logic owner_is_b(input int k);
    return (((k - 1) / MAX_HOLD) % 2) == 1;
  endfunction

  task automatic test_reset();
    #1 Reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #2;
      ReqA  = 1'($urandom);
      ReqB  = 1'($urandom);
      DataA = 8'($urandom);
      DataB = 8'($urandom);
      #0;
      n_checks++;
      if ({GntA, GntB, Busy} !== 3'b000 || Q !== 8'h00)
        $display("FAIL reset_hold[%0d]: got GntA=%b GntB=%b Busy=%b Q=%h want 0 0 0 00",
                 i, GntA, GntB, Busy, Q);
      else n_pass++;
    end
    #1;
    Reset = 1'b0;
    ReqA  = 1'b0;
    ReqB  = 1'b0;
  endtask

  task automatic test_single_write();
    logic [WIDTH-1:0] e;
    do_reset();
    ReqA  = 1'b1;
    DataA = 8'h3C;
    tick();
    n_checks++;
    if (GntA !== 1'b1 || GntB !== 1'b0 || Busy !== 1'b1 || Q !== 8'h00)
      $display("FAIL single_grant: got GntA=%b GntB=%b Busy=%b Q=%h want 1 0 1 00",
               GntA, GntB, Busy, Q);
    else n_pass++;
    exp_q.push_back(DataA);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (Q !== e) $display("FAIL single_q: got %h want %h", Q, e);
    else n_pass++;
    ReqA = 1'b0;
    DataA = 8'hFF;
    tick();
    n_checks++;
    if (GntA !== 1'b0 || Busy !== 1'b0 || Q !== 8'h3C)
      $display("FAIL single_release: got GntA=%b Busy=%b Q=%h want 0 0 3c", GntA, Busy, Q);
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [WIDTH-1:0] e;
    do_reset();
    ReqA  = 1'b1;
    ReqB  = 1'b1;
    DataB = 8'h22;
    for (int k = 1; k <= 6; k++) begin
      DataA = 8'h40 + 8'(k);
      DataB = 8'hB0 + 8'(k);
      if (k >= 2) exp_q.push_back((k <= 5) ? DataA : DataB);
      tick();
      n_checks++;
      if (GntA !== (k <= 4) || GntB !== (k >= 5))
        $display("FAIL rotate_gnt[%0d]: got GntA=%b GntB=%b want %b %b",
                 k, GntA, GntB, (k <= 4), (k >= 5));
      else n_pass++;
      if (k >= 2) begin
        e = exp_q.pop_front();
        n_checks++;
        if (Q !== e) $display("FAIL rotate_q[%0d]: got %h want %h", k, Q, e);
        else n_pass++;
      end
    end
    ReqA = 1'b0;
    ReqB = 1'b0;
  endtask

  task automatic test_alternation();
    logic [WIDTH-1:0] e;
    logic             exp_b;
    do_reset();
    ReqA = 1'b1;
    ReqB = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      DataA = 8'h10 + 8'(k);
      DataB = 8'h80 + 8'(k);
      if (k >= 2) exp_q.push_back(owner_is_b(k - 1) ? DataB : DataA);
      tick();
      exp_b = owner_is_b(k);
      n_checks++;
      if (GntA !== !exp_b || GntB !== exp_b)
        $display("FAIL alt_gnt[%0d]: got GntA=%b GntB=%b want %b %b",
                 k, GntA, GntB, !exp_b, exp_b);
      else n_pass++;
      if (k >= 2) begin
        e = exp_q.pop_front();
        n_checks++;
        if (Q !== e) $display("FAIL alt_q[%0d]: got %h want %h", k, Q, e);
        else n_pass++;
      end
    end
    ReqA = 1'b0;
    ReqB = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ReqB  = 1'b1;
    DataB = 8'hA5;
    tick();
    tick();
    n_checks++;
    if (GntB !== 1'b1 || Q !== 8'hA5)
      $display("FAIL midrst_pre: got GntB=%b Q=%h want 1 a5", GntB, Q);
    else n_pass++;
    #3;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (GntB !== 1'b0 || GntA !== 1'b0 || Busy !== 1'b0 || Q !== 8'h00)
      $display("FAIL midrst_async: got GntA=%b GntB=%b Busy=%b Q=%h want 0 0 0 00",
               GntA, GntB, Busy, Q);
    else n_pass++;
    tick();
    n_checks++;
    if (GntB !== 1'b0 || Q !== 8'h00)
      $display("FAIL midrst_held: got GntB=%b Q=%h want 0 00", GntB, Q);
    else n_pass++;
    Reset = 1'b0;
    ReqB  = 1'b0;
  endtask

  task automatic test_b_alone();
    logic [WIDTH-1:0] e;
    do_reset();
    ReqB = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      DataB = 8'($urandom);
      if (k >= 2) exp_q.push_back(DataB);
      tick();
      n_checks++;
      if (GntB !== 1'b1 || GntA !== 1'b0)
        $display("FAIL balone_gnt[%0d]: got GntA=%b GntB=%b want 0 1", k, GntA, GntB);
      else n_pass++;
      if (k >= 2) begin
        e = exp_q.pop_front();
        n_checks++;
        if (Q !== e) $display("FAIL balone_q[%0d]: got %h want %h", k, Q, e);
        else n_pass++;
      end
    end
    ReqB = 1'b0;
  endtask

  task automatic test_prio_and_handover();
    do_reset();
    ReqA  = 1'b1;
    DataA = 8'h5A;
    tick();
    tick();
    ReqA = 1'b0;
    tick();
    n_checks++;
    if (Busy !== 1'b0 || GntA !== 1'b0)
      $display("FAIL prio_idle: got Busy=%b GntA=%b want 0 0", Busy, GntA);
    else n_pass++;
    ReqA  = 1'b1;
    ReqB  = 1'b1;
    DataB = 8'hC3;
    tick();
    n_checks++;
    if (GntB !== 1'b1 || GntA !== 1'b0)
      $display("FAIL prio_tie: got GntA=%b GntB=%b want 0 1", GntA, GntB);
    else n_pass++;
    ReqB = 1'b0;
    DataA = 8'h77;
    tick();
    n_checks++;
    if (GntA !== 1'b1 || GntB !== 1'b0 || Busy !== 1'b1 || Q !== 8'h5A)
      $display("FAIL drop_handover: got GntA=%b GntB=%b Busy=%b Q=%h want 1 0 1 5a",
               GntA, GntB, Busy, Q);
    else n_pass++;
    tick();
    n_checks++;
    if (Q !== 8'h77) $display("FAIL drop_first_write: got %h want 77", Q);
    else n_pass++;
    ReqA = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_rotation();
    test_alternation();
    test_reset_mid();
    test_b_alone();
    test_prio_and_handover();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
